// File: rtl/div_unit.sv
// div_unit -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Sits in EX beside the ALU. A request is taken when START is high in IDLE or
// OUT. Divide-by-zero and signed overflow resolve on the accepting edge and go
// straight to OUT. Every other request runs 32 shift/subtract iterations (CALC),
// one sign-fix cycle (FIX), then pulses DONE for one cycle (OUT). BUSY is high
// in CALC and FIX so the front end can stall.
//
// Ports
//   CLK      in   rising-edge clock
//   RESET_N  in   asynchronous active-low reset
//   START    in   request; sampled only in IDLE or OUT
//   FUNCT    in   [1:0] 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   DATA1    in   [XLEN-1:0] dividend (rs1)
//   DATA2    in   [XLEN-1:0] divisor (rs2)
//   FLUSH    in   synchronous abort; wins over START
//   BUSY     out  high in CALC and FIX (pipeline stall)
//   DONE     out  one-cycle pulse in OUT; RESULT valid
//   RESULT   out  [XLEN-1:0] quotient or remainder; holds until the next write
//
// All outputs come straight from flops; there is no input-to-output path.

module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic            START,
   input  logic [1:0]      FUNCT,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   input  logic            FLUSH,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_OUT
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] rem;       // partial remainder
   logic [XLEN-1:0] quo;       // dividend shifts out the top, quotient in the bottom
   logic [XLEN-1:0] dvsr;      // divisor magnitude
   logic [1:0]      funct_q;
   logic            qneg;
   logic            rneg;

   // ------------------------------------------------------------------
   // Request decode (only meaningful while START is being sampled)
   // ------------------------------------------------------------------
   logic            is_signed;
   logic            neg1;
   logic            neg2;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] special_res;

   always_comb begin
      is_signed = ~FUNCT[0];
      neg1      = is_signed & DATA1[XLEN-1];
      neg2      = is_signed & DATA2[XLEN-1];
      mag1      = neg1 ? ({XLEN{1'b0}} - DATA1) : DATA1;
      mag2      = neg2 ? ({XLEN{1'b0}} - DATA2) : DATA2;
      div_zero  = (DATA2 == {XLEN{1'b0}});
      ovf       = is_signed & (DATA1 == MIN_NEG) & (&DATA2);
      // Divide-by-zero is checked first: -2^31 / 0 must give the zero-divisor
      // answers, not the overflow ones.
      if (div_zero)
         special_res = FUNCT[1] ? DATA1 : {XLEN{1'b1}};
      else
         special_res = FUNCT[1] ? {XLEN{1'b0}} : MIN_NEG;
   end

   // ------------------------------------------------------------------
   // One restoring step
   // ------------------------------------------------------------------
   // The shifted remainder can reach 2*divisor-1, which needs XLEN+1 bits;
   // one more bit on the trial holds the borrow that decides the quotient bit.
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] trial;
   logic            trial_ok;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;

   always_comb begin
      rem_sh   = {rem, quo[XLEN-1]};
      trial    = {1'b0, rem_sh} - {2'b00, dvsr};
      trial_ok = ~trial[XLEN+1];
      // A failed trial means rem_sh < divisor, so it already fits XLEN bits.
      rem_next = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], trial_ok};
   end

   // ------------------------------------------------------------------
   // Sign fix-up
   // ------------------------------------------------------------------
   logic [XLEN-1:0] fix_res;

   always_comb begin
      if (funct_q[1])
         fix_res = rneg ? ({XLEN{1'b0}} - rem) : rem;
      else
         fix_res = qneg ? ({XLEN{1'b0}} - quo) : quo;
   end

   // ------------------------------------------------------------------
   // Control and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= S_IDLE;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvsr    <= '0;
         funct_q <= '0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         RESULT  <= '0;
      end else if (FLUSH) begin
         // Abort wherever we are; RESULT keeps the last completed answer.
         state <= S_IDLE;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_OUT: begin
               BUSY <= 1'b0;
               DONE <= 1'b0;
               if (START) begin
                  funct_q <= FUNCT;
                  quo     <= mag1;
                  dvsr    <= mag2;
                  qneg    <= neg1 ^ neg2;
                  rneg    <= neg1;
                  rem     <= '0;
                  cnt     <= '0;
                  if (div_zero || ovf) begin
                     // Answer known now; skip the iterations entirely.
                     RESULT <= special_res;
                     DONE   <= 1'b1;
                     state  <= S_OUT;
                  end else begin
                     BUSY  <= 1'b1;
                     state <= S_CALC;
                  end
               end else begin
                  state <= S_IDLE;
               end
            end

            S_CALC: begin
               rem <= rem_next;
               quo <= quo_next;
               if (cnt == LAST_ITER)
                  state <= S_FIX;
               else
                  cnt <= cnt + 1'b1;
            end

            S_FIX: begin
               RESULT <= fix_res;
               BUSY   <= 1'b0;
               DONE   <= 1'b1;
               state  <= S_OUT;
            end

            default: begin
               BUSY  <= 1'b0;
               DONE  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected result, DONE cycle
// and BUSY run length; a negedge monitor pops and compares on every DONE.

module tb_div_unit;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        START;
   logic [1:0]  FUNCT;
   logic [31:0] DATA1;
   logic [31:0] DATA2;
   logic        FLUSH;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int busy_run = 0;
   logic [31:0] prev_res = 32'h0;

   typedef struct {
      logic [31:0] res;
      int          due;
      int          blen;
      int          id;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   div_unit #(.XLEN(32)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .FUNCT(FUNCT),
      .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: RISC-V M semantics from plain arithmetic.
   function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      int sa, sbv;
      if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'h0 : 32'h8000_0000;
         sa = a;
         sbv = b;
         return f[1] ? (sa % sbv) : (sa / sbv);
      end
      return f[1] ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [1:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'h0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Monitor: compare on every DONE; track the BUSY run that precedes it.
   always @(negedge CLK) begin
      if (DONE) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got DONE=1 want DONE=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("result#%0d", mon_e.id), RESULT, mon_e.res);
            chk($sformatf("done_cycle#%0d", mon_e.id), cyc, mon_e.due);
            chk($sformatf("busy_len#%0d", mon_e.id), busy_run, mon_e.blen);
         end
         busy_run = 0;
      end else if (BUSY) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   // Drive a request for one sampling edge; optionally register expectations.
   task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit special, input bit push,
                        input int id);
      exp_t e;
      FUNCT = f;
      DATA1 = a;
      DATA2 = b;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      if (push) begin
         e.res  = exp_res;
         e.due  = cyc + (special ? 0 : 33);
         e.blen = special ? 0 : 33;
         e.id   = id;
         sb.push_back(e);
         prev_res = exp_res;
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!DONE && n < 40) begin
         @(posedge CLK);
         #1;
         n++;
      end
      if (!DONE) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: DONE=0 after %0d cycles, want DONE=1", name, n);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  f;
      logic [31:0] a, b;
      START = 1'b0; FLUSH = 1'b0; FUNCT = 2'b00; DATA1 = '0; DATA2 = '0;
      RESET_N = 1'b1;
      #1 RESET_N = 1'b0;
      #1;
      chk("reset_busy", BUSY, 0);
      chk("reset_done", DONE, 0);
      chk("reset_result", RESULT, 0);
      @(posedge CLK); @(posedge CLK); #1 RESET_N = 1'b1;
      idle(1);

      // Signed with negative dividend
      issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1, 1); wait_done("div_m7_2"); idle(1);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1, 2); wait_done("rem_m7_2"); idle(1);
      // Unsigned full-range
      issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 0, 1, 3); wait_done("divu"); idle(1);
      issue(2'b11, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 0, 1, 4); wait_done("remu"); idle(1);
      // Divide by zero, all four ops
      issue(2'b00, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, 1, 5); wait_done("dz_div"); idle(1);
      issue(2'b01, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, 1, 6); wait_done("dz_divu"); idle(1);
      issue(2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, 1, 7); wait_done("dz_rem"); idle(1);
      issue(2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, 1, 8); wait_done("dz_remu"); idle(1);

      // Flush at cycle 10 of CALC: nothing expected from this request
      issue(2'b01, 32'd1000, 32'd3, 32'h0, 0, 0, 0);
      idle(9);
      FLUSH = 1'b1;
      idle(1);
      FLUSH = 1'b0;
      chk("flush_busy", BUSY, 0);
      chk("flush_done", DONE, 0);
      chk("flush_result", RESULT, prev_res);
      idle(40);

      // Signed overflow: short path for DIV/REM, full path for DIVU
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 9);  wait_done("ovf_div"); idle(1);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1, 10); wait_done("ovf_rem"); idle(1);
      issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 11); wait_done("ovf_divu"); idle(1);

      // Back-to-back: START held in OUT
      issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 0, 1, 12); wait_done("b2b_first");
      issue(2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 1, 13);
      chk("b2b_busy", BUSY, 1);
      wait_done("b2b_second"); idle(1);

      // Asynchronous reset mid-CALC
      issue(2'b00, 32'd100, 32'd7, 32'h0, 0, 0, 0);
      idle(10);
      #2 RESET_N = 1'b0;
      #1;
      chk("areset_busy", BUSY, 0);
      chk("areset_done", DONE, 0);
      chk("areset_result", RESULT, 0);
      @(posedge CLK); #1 RESET_N = 1'b1;
      prev_res = 32'h0;
      idle(2);

      // Random sweep, mixing idle gaps and back-to-back starts
      for (int i = 0; i < 1000; i++) begin
         f = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: a = $urandom_range(0, 15);
            4: b = -$urandom_range(1, 15);
            default: ;
         endcase
         issue(f, a, b, model(f, a, b), is_special(f, a, b), 1, 100 + i);
         wait_done("rand");
         if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 2));
      end

      idle(3);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
